// File: rtl/entropy_mcu_scheduler.sv
// MCU-order scheduler that interleaves Y/Cb/Cr coefficient blocks into one entropy coder,
// tracking per-component DC predictors and inserting restart-marker handshakes.
module entropy_mcu_scheduler #(
   parameter int DATA_WIDTH = 10,
   parameter int BLK_LEN    = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      cfg_subsamp,
   input  logic [15:0]               cfg_restart,
   input  logic [15:0]               num_mcu,
   input  logic [2:0]                in_valid,
   input  logic [3*DATA_WIDTH-1:0]   in_data,
   output logic [2:0]                in_ready,
   output logic                      out_valid,
   output logic [DATA_WIDTH-1:0]     out_data,
   output logic                      out_done,
   input  logic                      out_ready,
   output logic                      out_luma,
   output logic [1:0]                out_comp,
   output logic [DATA_WIDTH-1:0]     out_dc_pred,
   output logic                      rst_req,
   input  logic                      rst_ack,
   output logic [2:0]                rst_idx,
   output logic                      busy,
   output logic                      frame_done,
   output logic [2:0]                dbg_state
);

   localparam int CW = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;

   // Handshake: a coefficient moves on a cycle where out_valid && out_ready are both high;
   // in_ready of the scheduled component is a pure copy of out_ready, so it moves in the same cycle.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_BLOCK   = 3'd2,
      S_NEXT    = 3'd3,
      S_RESTART = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t                state, state_d;
   logic                  sub_r;
   logic [15:0]           restart_r, nmcu_r;
   logic [15:0]           mcu_cnt, rst_cnt;
   logic [2:0]            slot, slot_d;
   logic [CW-1:0]         coef_cnt;
   logic [DATA_WIDTH-1:0] pred_y, pred_cb, pred_cr;
   logic [DATA_WIDTH-1:0] dc_r;
   logic [2:0]            rst_idx_r;

   logic [1:0]            comp;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_valid;
   logic                  in_blk, xfer_v, xfer;
   logic                  last_coef, last_slot;
   logic [16:0]           mcu_inc, rst_inc;
   logic                  mcu_last, rst_hit;

   function automatic logic [1:0] slot_comp(input logic sub, input logic [2:0] s);
      if (sub) begin
         if (s < 3'd4)      slot_comp = 2'd0;
         else if (s == 3'd4) slot_comp = 2'd1;
         else               slot_comp = 2'd2;
      end else begin
         slot_comp = s[1:0];
      end
   endfunction

   function automatic logic [DATA_WIDTH-1:0] pred_sel(input logic [1:0] c,
                                                      input logic [DATA_WIDTH-1:0] py,
                                                      input logic [DATA_WIDTH-1:0] pb,
                                                      input logic [DATA_WIDTH-1:0] pr);
      case (c)
         2'd0:    pred_sel = py;
         2'd1:    pred_sel = pb;
         default: pred_sel = pr;
      endcase
   endfunction

   always_comb begin
      comp = slot_comp(sub_r, slot);
      case (comp)
         2'd0: begin
            sel_data  = in_data[DATA_WIDTH-1:0];
            sel_valid = in_valid[0];
         end
         2'd1: begin
            sel_data  = in_data[2*DATA_WIDTH-1:DATA_WIDTH];
            sel_valid = in_valid[1];
         end
         default: begin
            sel_data  = in_data[3*DATA_WIDTH-1:2*DATA_WIDTH];
            sel_valid = in_valid[2];
         end
      endcase
      in_blk    = (state == S_BLOCK);
      xfer_v    = in_blk && sel_valid;
      xfer      = xfer_v && out_ready;
      last_coef = (coef_cnt == CW'(BLK_LEN - 1));
      last_slot = (slot == (sub_r ? 3'd5 : 3'd2));
      // 17-bit sums so that a 65535-MCU frame compares without wrapping
      mcu_inc   = {1'b0, mcu_cnt} + 17'd1;
      rst_inc   = {1'b0, rst_cnt} + 17'd1;
      mcu_last  = (mcu_inc == {1'b0, nmcu_r});
      rst_hit   = (restart_r != 16'd0) && (rst_inc == {1'b0, restart_r});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      slot_d  = slot;
      case (state)
         S_IDLE:    if (start) state_d = S_LOAD;
         S_LOAD: begin
            slot_d  = 3'd0;
            state_d = (nmcu_r == 16'd0) ? S_DONE : S_BLOCK;
         end
         S_BLOCK:   if (xfer && last_coef) state_d = S_NEXT;
         S_NEXT: begin
            if (!last_slot) begin
               slot_d  = slot + 3'd1;
               state_d = S_BLOCK;
            end else begin
               slot_d = 3'd0;
               if (mcu_last)     state_d = S_DONE;
               else if (rst_hit) state_d = S_RESTART;
               else              state_d = S_BLOCK;
            end
         end
         S_RESTART: if (rst_ack) state_d = S_BLOCK;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_r     <= 1'b0;
         restart_r <= '0;
         nmcu_r    <= '0;
         mcu_cnt   <= '0;
         rst_cnt   <= '0;
         slot      <= '0;
         coef_cnt  <= '0;
         pred_y    <= '0;
         pred_cb   <= '0;
         pred_cr   <= '0;
         dc_r      <= '0;
         rst_idx_r <= '0;
      end else begin
         if (state == S_IDLE && start) begin
            sub_r     <= cfg_subsamp;
            restart_r <= cfg_restart;
            nmcu_r    <= num_mcu;
         end
         slot <= slot_d;
         case (state)
            S_LOAD: begin
               mcu_cnt  <= '0;
               rst_cnt  <= '0;
               coef_cnt <= '0;
               pred_y   <= '0;
               pred_cb  <= '0;
               pred_cr  <= '0;
               dc_r     <= '0;
            end
            S_BLOCK: begin
               if (xfer) begin
                  coef_cnt <= last_coef ? '0 : coef_cnt + CW'(1);
                  if (coef_cnt == '0) begin
                     case (comp)
                        2'd0:    pred_y  <= sel_data;
                        2'd1:    pred_cb <= sel_data;
                        default: pred_cr <= sel_data;
                     endcase
                  end
               end
            end
            S_NEXT: begin
               if (last_slot) begin
                  mcu_cnt <= mcu_inc[15:0];
                  rst_cnt <= (state_d == S_RESTART) ? 16'd0 : rst_inc[15:0];
               end
               if (state_d == S_RESTART) begin
                  pred_y  <= '0;
                  pred_cb <= '0;
                  pred_cr <= '0;
               end
            end
            S_RESTART: if (rst_ack) rst_idx_r <= rst_idx_r + 3'd1;
            default: ;
         endcase
         // Predictor snapshot at block entry; the live predictor may change during the block
         if (state_d == S_BLOCK && state != S_BLOCK && state != S_LOAD)
            dc_r <= pred_sel(slot_comp(sub_r, slot_d), pred_y, pred_cb, pred_cr);
      end
   end

   always_comb begin
      out_valid   = xfer_v;
      out_data    = in_blk ? sel_data : '0;
      in_ready    = (in_blk && out_ready) ? (3'b001 << comp) : 3'b000;
      out_done    = xfer_v && last_coef;
      out_luma    = in_blk && (comp == 2'd0);
      out_comp    = comp;
      out_dc_pred = dc_r;
      rst_req     = (state == S_RESTART);
      rst_idx     = rst_idx_r;
      busy        = (state != S_IDLE);
      frame_done  = (state == S_DONE);
      dbg_state   = state;
   end

endmodule
